// File: rtl/aes256_ct_driver.sv
// aes256_ct_driver: constant-time request/response front end for an external
// aes_256 core. A request is captured, the core inputs are held stable, and
// the core output is sampled after a fixed number of cycles that depends only
// on a counter, never on plaintext, key or ciphertext.
module aes256_ct_driver #(
  parameter int LATENCY = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [127:0]     req_state_i,
  input  logic [255:0]     req_key_i,
  output logic [127:0]     core_state_o,
  output logic [255:0]     core_key_o,
  input  logic [127:0]     core_out_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [127:0]     rsp_data_o,
  output logic             rsp_stable_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] txn_count_o
);

  localparam int LAT_W = $clog2(LATENCY);
  localparam logic [LAT_W-1:0] LAST = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LAT_W-1:0] cnt;
  logic [127:0]     out_q;

  logic fire_req;
  logic fire_rsp;
  logic done;

  // Handshake qualifiers depend only on control state, keeping timing data-independent.
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign fire_req    = req_ready_o & req_valid_i;
  assign fire_rsp    = rsp_valid_o & rsp_ready_i;
  assign done        = (state_q == BUSY) && (cnt == LAST);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic driven only by handshakes and the latency counter.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire_req) state_d = BUSY;
      BUSY:    if (done)     state_d = RESP;
      RESP:    if (fire_rsp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter: cleared on acceptance, counts every BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (fire_req)         cnt <= '0;
    else if (state_q == BUSY)  cnt <= cnt + 1'b1;
  end

  // Core input capture; held unchanged until the next accepted request.
  always_ff @(posedge clk) begin
    // NOTE: the wide datapath registers are reset too, so a mid-transaction
    // reset leaves no key material on the core inputs.
    if (!rst_n) begin
      core_state_o <= '0;
      core_key_o   <= '0;
    end else if (fire_req) begin
      core_state_o <= req_state_i;
      core_key_o   <= req_key_i;
    end
  end

  // One-cycle delayed copy of the core output, used only for the stability flag.
  always_ff @(posedge clk) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= core_out_i;
  end

  // Response register: sample at the fixed deadline, hold until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_stable_o <= 1'b0;
    end else if (done) begin
      rsp_valid_o  <= 1'b1;
      rsp_data_o   <= core_out_i;
      rsp_stable_o <= (core_out_i == out_q);
    end else if (fire_rsp) begin
      rsp_valid_o  <= 1'b0;
    end
  end

  // Completed-transaction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)        txn_count_o <= '0;
    else if (fire_rsp) txn_count_o <= txn_count_o + 1'b1;
  end

endmodule

// File: doc/aes256_ct_driver.md
Name: aes256_ct_driver

Overview:
- Request/response front end that feeds an externally instantiated aes_256 core.
- Accepts one plaintext/key pair per transaction over a valid/ready handshake and holds the core inputs stable while the core computes.
- Returns the ciphertext over a valid/ready handshake after a fixed, data-independent number of cycles.
- It is the producer-side counterpart of the constant-time harness: timing is set by a counter, never by data, so hyperproperty checks can compare two instances that differ only in secret key bits.

Parameters:
- LATENCY, 15, cycles from request acceptance to ciphertext sampling; legal range >= 2.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  block can accept a request.
- req_state_i  input  128  plaintext.
- req_key_i  input  256  key.
- core_state_o  output  128  plaintext driven to aes_256.state.
- core_key_o  output  256  key driven to aes_256.key.
- core_out_i  input  128  aes_256.out.
- rsp_valid_o  output  1  ciphertext valid.
- rsp_ready_i  input  1  consumer accepts ciphertext.
- rsp_data_o  output  128  ciphertext.
- rsp_stable_o  output  1  core_out_i was equal on the last two cycles at sampling; qualified by rsp_valid_o.
- busy_o  output  1  transaction in flight (BUSY or RESP).
- txn_count_o  output  CNT_W  completed transactions, wraps modulo 2^CNT_W.

Behaviour:
- Reset, rst_n low at a posedge:
  - state = IDLE; cnt = 0.
  - core_state_o, core_key_o, rsp_data_o, txn_count_o and out_q are all 0.
  - rsp_valid_o = 0; rsp_stable_o = 0.
  - Reset applies from any state, mid-transaction included; an in-flight transaction is discarded with no response.
- req_ready_o = (state == IDLE). Combinational, so it is 1 on the first cycle after reset.
- busy_o = (state != IDLE).
- States:
  - IDLE: on the edge where req_valid_i & req_ready_o, register req_state_i -> core_state_o and req_key_i -> core_key_o, set cnt = 0, go to BUSY.
  - BUSY: cnt increments by 1 every cycle. At the edge where cnt == LATENCY-1:
    - rsp_data_o <= core_out_i
    - rsp_stable_o <= (core_out_i == out_q)
    - rsp_valid_o <= 1
    - go to RESP.
    - req_valid_i is ignored in BUSY; core inputs do not change.
  - RESP: rsp_data_o and rsp_stable_o hold. On the edge where rsp_valid_o & rsp_ready_i: rsp_valid_o <= 0, txn_count_o <= txn_count_o + 1 (wraps), go to IDLE.
- Timing for a request accepted at edge T:
  - core inputs change after edge T.
  - rsp_valid_o is high from edge T+LATENCY.
  - With rsp_ready_i held high, the handshake occurs at T+LATENCY+1 and the next request can be accepted at T+LATENCY+2. The minimum issue interval is LATENCY+2.
- out_q <= core_out_i every cycle in every state (reset 0). It is used only for rsp_stable_o.
- In IDLE the core inputs hold the last captured values, so the core output stays stable between transactions.
- Constant-time requirements:
  - No state transition, counter, or handshake output depends on req_state_i, req_key_i, or core_out_i.
  - rsp_stable_o is a diagnostic only and never alters timing.
- Simultaneous events: rsp handshake and req_valid_i in the same cycle -> the request is not accepted in that cycle (ready = 0 in RESP) and is accepted in the following IDLE cycle if still valid.
- Holding conditions:
  - The requester must hold req_* stable while req_valid_i is high and ready is low.
  - The block holds rsp_data_o while rsp_valid_o is high and rsp_ready_i is low, for an unbounded number of cycles.

Test Plan:
1. FIPS-197 AES-256 vector: req_state_i=00112233445566778899aabbccddeeff, req_key_i=000102…1f, accepted at edge T, rsp_ready_i=1 -> rsp_valid_o rises at exactly T+15, rsp_data_o=8ea2b7ca516745bfeafc49904b496089, rsp_stable_o=1, txn_count_o=1 after the handshake.
2. Same request with rsp_ready_i low for 5 cycles after rsp_valid_o rises -> rsp_data_o constant, req_ready_o=0, busy_o=1; handshake at the 6th cycle, then req_ready_o=1.
3. Two runs differing only in key byte 0 (key ^ 0xFF) -> cycle-identical req_ready_o, rsp_valid_o and busy_o traces; rsp_data_o differs.
4. rst_n low at cnt=5 in BUSY -> next cycle state IDLE, req_ready_o=1, rsp_valid_o=0, core_state_o=0, core_key_o=0, txn_count_o=0; no response emitted.
5. req_valid_i held high with new data throughout BUSY -> core_state_o/core_key_o unchanged; the new request is accepted only at the first IDLE cycle (T+LATENCY+2 with rsp_ready_i=1).
6. CNT_W=2, 5 back-to-back transactions -> txn_count_o sequence 1,2,3,0,1; issue interval exactly LATENCY+2 each.
